// File: rtl/scenic_fifo_pkg.sv
// Shared definitions for the FIFO buffer bank: ctrl/resp bit positions and the
// output-feature drain FSM state encoding.
package scenic_fifo_pkg;

    localparam int WR_EN_BIT = 0;
    localparam int RD_EN_BIT = 1;
    localparam int FULL_BIT  = 0;
    localparam int EMPTY_BIT = 1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPTURE,
        SERIAL,
        DONE
    } drain_state_e;

endpackage

// File: rtl/of_bank_serializer.sv
// Holds one popped parallel OF word and streams it bank-by-bank on valid/ready.
// Build option OF_DRAIN_RELU_EN clamps negative lanes to zero at capture.
module of_bank_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 15,
    parameter int BANK_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture_i,
    input  logic [2*DATA_WIDTH-1:0]   lanes_i [NUM_BANKS],
    input  logic                      out_ready_i,
    output logic [2*DATA_WIDTH-1:0]   out_data_o,
    output logic [BANK_W-1:0]         out_bank_o,
    output logic                      out_last_o,
    output logic                      out_valid_o,
    output logic                      last_beat_o
);

    localparam int                LANE_W    = 2 * DATA_WIDTH;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    logic [LANE_W-1:0] hold_q    [NUM_BANKS];
    logic [LANE_W-1:0] lanes_cap [NUM_BANKS];
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              valid_q, valid_d;
    logic              at_last;

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
`ifdef OF_DRAIN_RELU_EN
            lanes_cap[b] = lanes_i[b][LANE_W-1] ? '0 : lanes_i[b];
`else
            lanes_cap[b] = lanes_i[b];
`endif
        end
    end

    assign at_last = (bank_q == LAST_BANK);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        bank_d  = bank_q;
        valid_d = valid_q;
        if (capture_i) begin
            bank_d  = '0;
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            if (at_last) begin
                valid_d = 1'b0;
            end else begin
                bank_d = bank_q + BANK_W'(1);
            end
        end
    end

    // NOTE: the holding register is reset on purpose so outputs read 0 after reset; plain
    // data storage would normally be left unreset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                hold_q[b] <= '0;
            end
            bank_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (capture_i) begin
                hold_q <= lanes_cap;
            end
            bank_q  <= bank_d;
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = hold_q[bank_q];
    assign out_bank_o  = bank_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = valid_q && at_last;
    assign last_beat_o = valid_q && out_ready_i && at_last;

endmodule

// File: rtl/of_drain_ctrl.sv
// Pops NUM_BANKS output-feature FIFOs in lock-step and serialises each word onto
// one stream for a programmed word count. Build option: OF_DRAIN_RELU_EN.
module of_drain_ctrl
    import scenic_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 15,
    parameter int CNT_WIDTH  = 16,
    parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [CNT_WIDTH-1:0]      num_words_i,
    output logic [1:0]                of_fifo_ctrl,
    input  logic [1:0]                of_fifo_resp,
    input  logic [2*DATA_WIDTH-1:0]   rd_of_data_i [NUM_BANKS],
    output logic [2*DATA_WIDTH-1:0]   out_data_o,
    output logic [BANK_W-1:0]         out_bank_o,
    output logic                      out_last_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      busy_o,
    output logic                      done_o
);

    drain_state_e         state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 fifo_empty;
    logic                 last_beat;
    logic                 unused_full;

    assign fifo_empty  = of_fifo_resp[EMPTY_BIT];
    assign unused_full = of_fifo_resp[FULL_BIT];

    // Only POP may read, which keeps at most one pop in flight.
    assign of_fifo_ctrl[RD_EN_BIT] = (state_q == POP) && !fifo_empty;
    assign of_fifo_ctrl[WR_EN_BIT] = 1'b0;

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (num_words_i != '0) begin
                            cnt_q   <= num_words_i;
                            busy_q  <= 1'b1;
                            state_q <= POP;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                POP: begin
                    if (!fifo_empty) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q <= SERIAL;
                end
                SERIAL: begin
                    if (last_beat) begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                        if (cnt_q == CNT_WIDTH'(1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= POP;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

    of_bank_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BANKS  (NUM_BANKS),
        .BANK_W     (BANK_W)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (state_q == CAPTURE),
        .lanes_i     (rd_of_data_i),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_bank_o  (out_bank_o),
        .out_last_o  (out_last_o),
        .out_valid_o (out_valid_o),
        .last_beat_o (last_beat)
    );

endmodule

// File: tb/tb_of_drain_ctrl.sv
// Directed bench for of_drain_ctrl with a small behavioural OF FIFO (one-cycle read latency).
module tb_of_drain_ctrl;

    localparam int DW = 8;
    localparam int NB = 15;
    localparam int CW = 16;
    localparam int LW = 2 * DW;
    localparam int BW = 4;

    typedef logic [NB-1:0][LW-1:0] word_t;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [CW-1:0] num_words_i;
    logic [1:0]    of_fifo_ctrl;
    logic [1:0]    of_fifo_resp;
    logic [LW-1:0] rd_of_data_i [NB];
    logic [LW-1:0] out_data_o;
    logic [BW-1:0] out_bank_o;
    logic          out_last_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          busy_o;
    logic          done_o;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model: initial block pushes, the always block pops.
    word_t       mem [16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty;
    logic        fifo_empty;
    word_t       rd_word;
    logic [LW-1:0] exp_q [$];

    of_drain_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_BANKS  (NB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .num_words_i  (num_words_i),
        .of_fifo_ctrl (of_fifo_ctrl),
        .of_fifo_resp (of_fifo_resp),
        .rd_of_data_i (rd_of_data_i),
        .out_data_o   (out_data_o),
        .out_bank_o   (out_bank_o),
        .out_last_o   (out_last_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty   = force_empty || (wr_ptr == rd_ptr);
    assign of_fifo_resp = {fifo_empty, 1'b0};

    always @(posedge clk) begin
        if (of_fifo_ctrl[1]) begin
            rd_word <= mem[rd_ptr % 16];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            rd_of_data_i[b] = rd_word[b];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input word_t w, input word_t e);
        mem[wr_ptr % 16] = w;
        wr_ptr = wr_ptr + 1;
        for (int b = 0; b < NB; b++) begin
            exp_q.push_back(e[b]);
        end
    endtask

    function automatic word_t ramp(input logic [LW-1:0] base);
        word_t w;
        for (int b = 0; b < NB; b++) begin
            w[b] = base + LW'(b);
        end
        return w;
    endfunction

    // Starts a drain at a negedge and monitors until done_o or the cycle budget runs out.
    // Cycle 0 is the first cycle after the start edge (the first POP cycle).
    task automatic run_drain(input int num, input int stall, input bit rnd, input int restart_at,
                             input int budget, output int rd_cnt, output int first_rd,
                             output int first_beat, output int beats, output int done_cyc,
                             output int valid_in_stall);
        bit            prev_stall;
        logic [LW-1:0] prev_data;
        logic [BW-1:0] prev_bank;
        logic          prev_last;
        logic [LW-1:0] exp;
        int            beat_idx;
        beat_idx = 0;
        rd_cnt = 0; first_rd = -1; first_beat = -1; beats = 0; done_cyc = -1; valid_in_stall = 0;
        prev_stall = 1'b0; prev_data = '0; prev_bank = '0; prev_last = 1'b0;
        force_empty = (stall > 0);
        start_i     = 1'b1;
        num_words_i = CW'(num);
        @(negedge clk);
        for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
            if (stall > 0 && cyc == stall) force_empty = 1'b0;
            if (cyc == restart_at) begin
                start_i     = 1'b1;
                num_words_i = CW'(5);
            end else begin
                start_i = 1'b0;
            end
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (of_fifo_ctrl[1]) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (stall > 0 && cyc < stall && out_valid_o) valid_in_stall++;
            if (done_o) done_cyc = cyc;
            if (out_valid_o) begin
                if (prev_stall) begin
                    check("stall_data", 32'(out_data_o), 32'(prev_data));
                    check("stall_bank", 32'(out_bank_o), 32'(prev_bank));
                    check("stall_last", 32'(out_last_o), 32'(prev_last));
                end
                if (out_ready_i) begin
                    if (first_beat < 0) first_beat = cyc;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'(1), 32'(0));
                    end else begin
                        exp = exp_q.pop_front();
                        check("beat_data", 32'(out_data_o), 32'(exp));
                    end
                    check("beat_bank", 32'(out_bank_o), 32'(beat_idx % NB));
                    check("beat_last", 32'(out_last_o), 32'((beat_idx % NB) == NB - 1));
                    beat_idx++;
                    beats++;
                end
                prev_stall = !out_ready_i;
                prev_data  = out_data_o;
                prev_bank  = out_bank_o;
                prev_last  = out_last_o;
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge clk);
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        force_empty = 1'b0;
        check("done_seen", 32'(done_cyc >= 0), 32'(1));
    endtask

    initial begin
        int    rd_cnt, first_rd, first_beat, beats, done_cyc, vis;
        bit    found;
        word_t w, e;

        rst         = 1'b0;
        start_i     = 1'b0;
        num_words_i = '0;
        out_ready_i = 1'b1;
        force_empty = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(out_valid_o), 32'(0));
        check("rst_ctrl",  32'(of_fifo_ctrl), 32'(0));
        check("rst_busy",  32'(busy_o), 32'(0));
        check("rst_done",  32'(done_o), 32'(0));
        check("rst_data",  32'(out_data_o), 32'(0));
        check("rst_bank",  32'(out_bank_o), 32'(0));
        check("rst_last",  32'(out_last_o), 32'(0));
        rst = 1'b1;
        @(negedge clk);

        // Basic drain: two words, ready held high.
        push_word(ramp(16'h0100), ramp(16'h0100));
        push_word(ramp(16'h0200), ramp(16'h0200));
        run_drain(2, 0, 1'b0, -1, 100, rd_cnt, first_rd, first_beat, beats, done_cyc, vis);
        check("basic_rd_cnt",     32'(rd_cnt), 32'(2));
        check("basic_first_rd",   32'(first_rd), 32'(0));
        check("basic_first_beat", 32'(first_beat), 32'(2));
        check("basic_beats",      32'(beats), 32'(30));
        check("basic_done_cyc",   32'(done_cyc), 32'(34));
        #1;
        check("basic_done_pulse", 32'(done_o), 32'(0));
        check("basic_busy_after", 32'(busy_o), 32'(0));
        @(negedge clk);

        // Empty stall: FIFO reports empty for 10 cycles.
        push_word(ramp(16'h0A00), ramp(16'h0A00));
        run_drain(1, 10, 1'b0, -1, 100, rd_cnt, first_rd, first_beat, beats, done_cyc, vis);
        check("stall_rd_cnt",     32'(rd_cnt), 32'(1));
        check("stall_first_rd",   32'(first_rd), 32'(10));
        check("stall_valid",      32'(vis), 32'(0));
        check("stall_first_beat", 32'(first_beat), 32'(12));
        check("stall_beats",      32'(beats), 32'(15));

        // Backpressure: random ready.
        push_word(ramp(16'h0300), ramp(16'h0300));
        run_drain(1, 0, 1'b1, -1, 400, rd_cnt, first_rd, first_beat, beats, done_cyc, vis);
        check("bp_beats",  32'(beats), 32'(15));
        check("bp_rd_cnt", 32'(rd_cnt), 32'(1));
        check("bp_left",   32'(exp_q.size()), 32'(0));

        // Zero count: done next cycle, no pop.
        start_i     = 1'b1;
        num_words_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("zero_done", 32'(done_o), 32'(1));
        check("zero_busy", 32'(busy_o), 32'(0));
        check("zero_rd",   32'(of_fifo_ctrl), 32'(0));
        @(negedge clk);
        #1;
        check("zero_done_clear", 32'(done_o), 32'(0));
        @(negedge clk);

        // Start while busy is ignored: count stays 1.
        push_word(ramp(16'h0400), ramp(16'h0400));
        run_drain(1, 0, 1'b0, 5, 100, rd_cnt, first_rd, first_beat, beats, done_cyc, vis);
        check("busy_done_cyc", 32'(done_cyc), 32'(17));
        check("busy_beats",    32'(beats), 32'(15));
        check("busy_rd_cnt",   32'(rd_cnt), 32'(1));
        repeat (3) @(negedge clk);
        #1;
        check("busy_idle_after", 32'({busy_o, out_valid_o, of_fifo_ctrl[1]}), 32'(0));
        @(negedge clk);

        // Reset mid-SERIAL at bank 7, then drain the next FIFO word.
        push_word(ramp(16'h0500), ramp(16'h0500));
        push_word(ramp(16'h0600), ramp(16'h0600));
        start_i     = 1'b1;
        num_words_i = CW'(2);
        @(negedge clk);
        start_i = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            out_ready_i = 1'b1;
            #1;
            if (out_valid_o && out_bank_o == BW'(7)) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_bank7_reached", 32'(found), 32'(1));
        check("rst_bank7_data", 32'(out_data_o), 32'(16'h0507));
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_valid", 32'(out_valid_o), 32'(0));
        check("midrst_data",  32'(out_data_o), 32'(0));
        check("midrst_bank",  32'(out_bank_o), 32'(0));
        check("midrst_last",  32'(out_last_o), 32'(0));
        check("midrst_busy",  32'(busy_o), 32'(0));
        check("midrst_done",  32'(done_o), 32'(0));
        check("midrst_ctrl",  32'(of_fifo_ctrl), 32'(0));
        rst = 1'b1;
        exp_q.delete();
        for (int b = 0; b < NB; b++) exp_q.push_back(16'h0600 + LW'(b));
        @(negedge clk);
        run_drain(1, 0, 1'b0, -1, 100, rd_cnt, first_rd, first_beat, beats, done_cyc, vis);
        check("postrst_beats",    32'(beats), 32'(15));
        check("postrst_done_cyc", 32'(done_cyc), 32'(17));

        // ReLU lanes: negative lane clamps only when the build option is on.
        w = ramp(16'h0700);
        w[0] = 16'hFFF0;
        w[1] = 16'h0012;
        e = w;
`ifdef OF_DRAIN_RELU_EN
        e[0] = 16'h0000;
`else
        e[0] = 16'hFFF0;
`endif
        e[1] = 16'h0012;
        push_word(w, e);
        run_drain(1, 0, 1'b0, -1, 100, rd_cnt, first_rd, first_beat, beats, done_cyc, vis);
        check("relu_beats", 32'(beats), 32'(15));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/of_drain_ctrl.md
Name: of_drain_ctrl

Overview:
- Downstream stage of the FIFO buffer bank. It pops one word from all NUM_BANKS output-feature (OF) FIFOs in lock-step, using the shared of_fifo_ctrl / of_fifo_resp pair.
- It serialises the captured parallel word bank-by-bank onto a single valid/ready stream toward the writeback / DMA path.
- It runs a programmed number of words per start command.

Parameters:
DATA_WIDTH, 8, input-feature width; OF lanes are 2*DATA_WIDTH
NUM_BANKS, 15, number of OF FIFOs drained in parallel
CNT_WIDTH, 16, width of the word-count register

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start_i  in  1  one-cycle pulse; latches num_words_i and begins draining
num_words_i  in  CNT_WIDTH  number of parallel FIFO words to drain
of_fifo_ctrl  out  2  bit0 = wr_en (always 0), bit1 = rd_en
of_fifo_resp  in  2  bit0 = full (ignored), bit1 = empty
rd_of_data_i  in  [NUM_BANKS] x 2*DATA_WIDTH  FIFO read data, unpacked array indexed by bank
out_data_o  out  2*DATA_WIDTH  serialised lane data
out_bank_o  out  $clog2(NUM_BANKS)  bank index of out_data_o
out_last_o  out  1  high with the final bank (NUM_BANKS-1) of each word
out_valid_o  out  1  stream valid
out_ready_i  in  1  stream ready
busy_o  out  1  high from accepted start until done
done_o  out  1  one-cycle pulse when the programmed count is finished

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = IDLE; of_fifo_ctrl, out_valid_o, busy_o, done_o all 0.
  - out_data_o, out_bank_o and out_last_o are 0; word counter and holding register are cleared.
  - Reset mid-operation abandons the transfer. Already-popped data is lost; the FIFO itself is not touched.
- FIFO timing: read data is valid on rd_of_data_i exactly one cycle after a cycle in which rd_en = 1.
- States:
  - IDLE:
    - On start_i with num_words_i != 0: latch the count, busy_o = 1, go to POP.
    - On start_i with num_words_i == 0: pulse done_o next cycle, stay IDLE, busy_o stays 0.
  - POP:
    - rd_en = 1 combinationally only while empty == 0, then go to CAPTURE.
    - While empty == 1: stay in POP with rd_en = 0.
  - CAPTURE: register all NUM_BANKS lanes of rd_of_data_i into the holding register, bank index = 0, go to SERIAL.
  - SERIAL:
    - out_valid_o = 1 and out_data_o = hold[bank]; a transfer occurs when out_valid_o && out_ready_i.
    - On a transfer with bank < NUM_BANKS-1: bank is incremented.
    - On a transfer with bank == NUM_BANKS-1 (out_last_o = 1): decrement the word counter. If the result is 0, go to DONE; otherwise go to POP.
    - While out_ready_i == 0: out_data_o, out_bank_o and out_last_o are held stable.
  - DONE: done_o = 1 for one cycle, busy_o = 0, return to IDLE.
- rd_en is never asserted outside POP, so at most one pop is outstanding.
- Throughput: NUM_BANKS + 2 cycles per word with ready held high and FIFO non-empty.
- start_i while busy_o == 1 is ignored.
- of_fifo_ctrl bit0 is tied to 0.

Optional Feature:
Macro OF_DRAIN_RELU_EN.
- Defined: each lane is treated as signed 2*DATA_WIDTH. Values with MSB = 1 are replaced by 0 on the CAPTURE path before storage, so out_data_o is never negative. No extra latency.
- Undefined: lanes pass unchanged.

Decomposition:
- Shared package scenic_fifo_pkg holds:
  - FIFO ctrl/resp bit-index constants (WR_EN_BIT = 0, RD_EN_BIT = 1, FULL_BIT = 0, EMPTY_BIT = 1).
  - The drain state enum typedef (IDLE, POP, CAPTURE, SERIAL, DONE).
- One sub-module, of_bank_serializer: holding register, bank counter, valid/ready output and the optional ReLU. The FSM and word counter stay in of_drain_ctrl.

Test Plan:
- Basic drain: NUM_BANKS = 15, FIFO preloaded with 2 words (lane i = 16'h0100 + i, then 16'h0200 + i), start with num_words = 2, ready = 1.
  - Required: 30 beats in order 0x0100..0x010E then 0x0200..0x020E; out_last_o on beats 15 and 30.
  - Required: done_o pulse 34 cycles after the first POP cycle; rd_en high exactly 2 cycles.
- Empty stall: start with num_words = 1 while empty = 1 for 10 cycles.
  - Required: rd_en = 0 and out_valid_o = 0 throughout; once empty drops, the pop occurs and the first beat appears 2 cycles later.
- Backpressure: toggle out_ready_i 1-0-0-1 randomly.
  - Required: no beat lost or duplicated; data, bank and last stable during stalls; total 15 accepted beats.
- Zero count / busy start: num_words = 0 gives done_o the next cycle with no rd_en. A second start_i mid-drain does not change the count.
- Reset mid-SERIAL: assert rst at bank 7.
  - Required: the next cycle shows all outputs 0 and IDLE; a following start drains the next FIFO word normally.
- OF_DRAIN_RELU_EN: lane values 16'hFFF0 and 16'h0012 are output as 0x0000 and 0x0012 with the macro defined, and unchanged without it.
